// File: rtl/ttt_event_router_pkg.sv
// ---------------------------------------------------------------------------
// ttt_pkg
// Shared types and helpers for the TTT event router.
//   router_state_t : sequencer states (IDLE, SCAN, ROUTE, DONE)
//   event_sign     : maps a {start, stop} pair to +1 / -1 / 0
//   sat_add        : signed add clamped to the range of a given bit width
// ---------------------------------------------------------------------------
package ttt_pkg;

    localparam int DEF_NUM_PROCESSORS  = 10;
    localparam int DEF_NEW_TOKENS_BITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_ROUTE = 2'd2,
        ST_DONE  = 2'd3
    } router_state_t;

    // {start, stop}: a lone start pushes a token, a lone stop pulls one,
    // both or neither cancel out and the source contributes nothing.
    function automatic logic signed [1:0] event_sign(input logic [1:0] ev);
        logic signed [1:0] sign_s;
        case (ev)
            2'b10:   sign_s = 2'sb01;
            2'b01:   sign_s = 2'sb11;
            default: sign_s = 2'sb00;
        endcase
        return sign_s;
    endfunction

    // Result is clamped to [-2^(width-1), 2^(width-1)-1]; the caller
    // truncates the returned int back to width bits.
    function automatic int sat_add(input int a, input int b, input int width);
        int sum_s;
        int max_s;
        int min_s;
        sum_s = a + b;
        max_s = (32'sd1 <<< (width - 1)) - 32'sd1;
        min_s = -max_s - 32'sd1;
        if (sum_s > max_s) begin
            return max_s;
        end else if (sum_s < min_s) begin
            return min_s;
        end else begin
            return sum_s;
        end
    endfunction

endpackage

// File: rtl/ttt_event_router_if.sv
// ---------------------------------------------------------------------------
// ttt_event_router_if
// Lookup bus between the router and the external connection table.
//   src_idx     : source whose fan-out range is being queried (router out)
//   range_start : first connection entry of that source (table out, comb)
//   range_stop  : one past the last entry (table out, comb)
//   conn_idx    : connection entry being routed (router out)
//   conn_tgt    : target processor of conn_idx (table out, comb)
//   conn_is_bad : entry carries bad tokens when set (table out, comb)
// master = router side, slave = table side.
// ---------------------------------------------------------------------------
interface ttt_event_router_if #(
    parameter int IDX_BITS  = 4,
    parameter int CONN_BITS = 8
);
    logic [IDX_BITS-1:0]  src_idx;
    logic [CONN_BITS-1:0] range_start;
    logic [CONN_BITS-1:0] range_stop;
    logic [CONN_BITS-1:0] conn_idx;
    logic [IDX_BITS-1:0]  conn_tgt;
    logic                 conn_is_bad;

    modport master (
        output src_idx,
        output conn_idx,
        input  range_start,
        input  range_stop,
        input  conn_tgt,
        input  conn_is_bad
    );

    modport slave (
        input  src_idx,
        input  conn_idx,
        output range_start,
        output range_stop,
        output conn_tgt,
        output conn_is_bad
    );
endinterface

// File: rtl/ttt_token_accumulator.sv
// ---------------------------------------------------------------------------
// ttt_token_accumulator
// Bank of NUM saturating signed token counters.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : zero every counter (wins over add_en)
//   add_en     : add add_val to counter add_idx this cycle
//   add_idx    : target counter; indices >= NUM are silently dropped
//   add_val    : signed delta (-1, 0, +1)
//   tokens     : registered counter values
// ---------------------------------------------------------------------------
module ttt_token_accumulator
    import ttt_pkg::*;
#(
    parameter int NUM        = 10,
    parameter int TOKEN_BITS = 4,
    parameter int IDX_BITS   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         add_en,
    input  logic [IDX_BITS-1:0]          add_idx,
    input  logic signed [1:0]            add_val,
    output logic signed [TOKEN_BITS-1:0] tokens [NUM]
);

    logic idx_ok_s;

    // Out-of-range targets are dropped rather than aliased onto a counter.
    always_comb begin
        idx_ok_s = 1'b0;
        if (32'(add_idx) < NUM) begin
            idx_ok_s = 1'b1;
        end else begin
            idx_ok_s = 1'b0;
        end
    end

    // Counter bank: clear on pass start, saturating update on each routed entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM; i++) begin
                tokens[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < NUM; i++) begin
                tokens[i] <= '0;
            end
        end else if (add_en && idx_ok_s) begin
            tokens[add_idx] <= TOKEN_BITS'(sat_add(32'(tokens[add_idx]), 32'(add_val), TOKEN_BITS));
        end
    end

endmodule

// File: rtl/ttt_event_router.sv
// ---------------------------------------------------------------------------
// ttt_event_router
// Per-pass sequencer: scans every processor's {start, stop} event, walks each
// active source's fan-out range in the connection table one entry per cycle,
// and accumulates saturating good/bad token deltas per target processor.
//   clk, reset      : clock, asynchronous active-high reset
//   go              : start a pass (honoured only while idle)
//   tstartstop      : {start, stop} per processor, captured on accepted go
//   tbl             : connection-table lookup bus (master side)
//   new_good_tokens : per-target good delta, valid when done = 1
//   new_bad_tokens  : per-target bad delta, valid when done = 1
//   busy            : pass in progress (SCAN, ROUTE, DONE)
//   done            : one-cycle pulse at pass end
//   enable          : high while idle so processors may advance
// ---------------------------------------------------------------------------
module ttt_event_router
    import ttt_pkg::*;
#(
    parameter int NUM_PROCESSORS  = DEF_NUM_PROCESSORS,
    parameter int NEW_TOKENS_BITS = DEF_NEW_TOKENS_BITS,
    parameter int IDX_BITS        = $clog2(NUM_PROCESSORS),
    parameter int CONN_BITS       = 2 * IDX_BITS
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              go,
    input  logic [1:0]                        tstartstop [NUM_PROCESSORS],
    ttt_event_router_if.master                tbl,
    output logic signed [NEW_TOKENS_BITS-1:0] new_good_tokens [NUM_PROCESSORS],
    output logic signed [NEW_TOKENS_BITS-1:0] new_bad_tokens  [NUM_PROCESSORS],
    output logic                              busy,
    output logic                              done,
    output logic                              enable
);

    localparam logic [IDX_BITS-1:0]  IDX_ONE  = IDX_BITS'(1);
    localparam logic [IDX_BITS-1:0]  IDX_LAST = IDX_BITS'(NUM_PROCESSORS - 1);
    localparam logic [CONN_BITS-1:0] CONN_ONE = CONN_BITS'(1);

    router_state_t         state_r;
    logic [1:0]            events_r [NUM_PROCESSORS];
    logic [IDX_BITS-1:0]   src_idx_r;
    logic [CONN_BITS-1:0]  conn_idx_r;
    logic [CONN_BITS-1:0]  stop_r;
    logic signed [1:0]     sign_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  enable_r;

    logic signed [1:0]     scan_sign_s;
    logic                  scan_hit_s;
    logic                  last_src_s;
    logic                  last_conn_s;
    logic                  clear_s;
    logic                  add_good_s;
    logic                  add_bad_s;

    // Decode of the current source/entry; events come from the captured copy
    // so mid-pass changes on tstartstop cannot leak in.
    always_comb begin
        scan_sign_s = event_sign(events_r[src_idx_r]);
        scan_hit_s  = 1'b0;
        if ((scan_sign_s != 2'sb00) && (tbl.range_start < tbl.range_stop)) begin
            scan_hit_s = 1'b1;
        end else begin
            scan_hit_s = 1'b0;
        end
        last_src_s  = (src_idx_r == IDX_LAST);
        last_conn_s = (conn_idx_r == (stop_r - CONN_ONE));
        clear_s     = (state_r == ST_IDLE) && go;
        add_good_s  = (state_r == ST_ROUTE) && !tbl.conn_is_bad;
        add_bad_s   = (state_r == ST_ROUTE) && tbl.conn_is_bad;
    end

    // Pass sequencer with registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            src_idx_r  <= '0;
            conn_idx_r <= '0;
            stop_r     <= '0;
            sign_r     <= 2'sb00;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            enable_r   <= 1'b1;
            for (int i = 0; i < NUM_PROCESSORS; i++) begin
                events_r[i] <= 2'b00;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (go) begin
                        for (int i = 0; i < NUM_PROCESSORS; i++) begin
                            events_r[i] <= tstartstop[i];
                        end
                        src_idx_r <= '0;
                        state_r   <= ST_SCAN;
                        busy_r    <= 1'b1;
                        enable_r  <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (scan_hit_s) begin
                        conn_idx_r <= tbl.range_start;
                        stop_r     <= tbl.range_stop;
                        sign_r     <= scan_sign_s;
                        state_r    <= ST_ROUTE;
                    end else if (last_src_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        src_idx_r <= src_idx_r + IDX_ONE;
                    end
                end
                ST_ROUTE: begin
                    // The last entry of a range hands straight over to the
                    // next source's SCAN cycle (or DONE) without an idle gap.
                    if (!last_conn_s) begin
                        conn_idx_r <= conn_idx_r + CONN_ONE;
                    end else if (last_src_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        src_idx_r <= src_idx_r + IDX_ONE;
                        state_r   <= ST_SCAN;
                    end
                end
                ST_DONE: begin
                    state_r  <= ST_IDLE;
                    done_r   <= 1'b0;
                    busy_r   <= 1'b0;
                    enable_r <= 1'b1;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    done_r   <= 1'b0;
                    busy_r   <= 1'b0;
                    enable_r <= 1'b1;
                end
            endcase
        end
    end

    assign tbl.src_idx  = src_idx_r;
    assign tbl.conn_idx = conn_idx_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign enable       = enable_r;

    ttt_token_accumulator #(
        .NUM        (NUM_PROCESSORS),
        .TOKEN_BITS (NEW_TOKENS_BITS),
        .IDX_BITS   (IDX_BITS)
    ) u_good_acc (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear_s),
        .add_en  (add_good_s),
        .add_idx (tbl.conn_tgt),
        .add_val (sign_r),
        .tokens  (new_good_tokens)
    );

    ttt_token_accumulator #(
        .NUM        (NUM_PROCESSORS),
        .TOKEN_BITS (NEW_TOKENS_BITS),
        .IDX_BITS   (IDX_BITS)
    ) u_bad_acc (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear_s),
        .add_en  (add_bad_s),
        .add_idx (tbl.conn_tgt),
        .add_val (sign_r),
        .tokens  (new_bad_tokens)
    );

endmodule

// File: tb/tb_ttt_event_router.sv
// ---------------------------------------------------------------------------
// tb_ttt_event_router
// Scoreboard bench for ttt_event_router with N=4, B=4, CONN_BITS=4.
// Each pass pushes the reference result (tokens and done cycle) into a
// queue; a monitor pops and compares whenever done is seen.
// ---------------------------------------------------------------------------
module tb_ttt_event_router;

    localparam int N  = 4;
    localparam int B  = 4;
    localparam int NE = 16;

    typedef struct packed {
        logic [N-1:0][B-1:0] good;
        logic [N-1:0][B-1:0] bad;
        int                  done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic go = 1'b0;
    logic [1:0] ev [N];
    logic signed [B-1:0] good_tok [N];
    logic signed [B-1:0] bad_tok [N];
    logic busy;
    logic done;
    logic enable;

    logic [3:0] rs [N];
    logic [3:0] re [N];
    logic [1:0] tgt [NE];
    logic       isbad [NE];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_seen = 0;
    exp_t exp_q [$];

    ttt_event_router_if #(.IDX_BITS(2), .CONN_BITS(4)) tbl ();

    assign tbl.range_start = rs[tbl.src_idx];
    assign tbl.range_stop  = re[tbl.src_idx];
    assign tbl.conn_tgt    = tgt[tbl.conn_idx];
    assign tbl.conn_is_bad = isbad[tbl.conn_idx];

    ttt_event_router #(.NUM_PROCESSORS(N), .NEW_TOKENS_BITS(B)) dut (
        .clk             (clk),
        .reset           (reset),
        .go              (go),
        .tstartstop      (ev),
        .tbl             (tbl),
        .new_good_tokens (good_tok),
        .new_bad_tokens  (bad_tok),
        .busy            (busy),
        .done            (done),
        .enable          (enable)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > 7) return 7;
        if (v < -8) return -8;
        return v;
    endfunction

    // Reference: total fan-out sets pass length; every routed entry is a
    // saturating +/-1 on its target, applied in source then entry order.
    function automatic exp_t model(input int go_edge);
        exp_t r;
        int g [N];
        int b [N];
        int fan;
        int sgn;
        fan = 0;
        for (int t = 0; t < N; t++) begin
            g[t] = 0;
            b[t] = 0;
        end
        for (int s = 0; s < N; s++) begin
            if (ev[s] == 2'b10) sgn = 1;
            else if (ev[s] == 2'b01) sgn = -1;
            else sgn = 0;
            if (sgn != 0) begin
                for (int e = int'(rs[s]); e < int'(re[s]); e++) begin
                    fan++;
                    if (int'(tgt[e]) < N) begin
                        if (isbad[e]) b[tgt[e]] = clamp(b[tgt[e]] + sgn);
                        else g[tgt[e]] = clamp(g[tgt[e]] + sgn);
                    end
                end
            end
        end
        for (int t = 0; t < N; t++) begin
            r.good[t] = 4'(g[t]);
            r.bad[t]  = 4'(b[t]);
        end
        r.done_cyc = go_edge + N + fan + 1;
        return r;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding pass.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_cycle", cyc, e.done_cyc);
                check("busy_at_done", int'(busy), 1);
                check("enable_at_done", int'(enable), 0);
                for (int t = 0; t < N; t++) begin
                    check($sformatf("good[%0d]", t), int'(good_tok[t]), int'($signed(e.good[t])));
                    check($sformatf("bad[%0d]", t), int'(bad_tok[t]), int'($signed(e.bad[t])));
                end
            end
            done_seen++;
        end
    end

    task automatic clear_table();
        for (int s = 0; s < N; s++) begin
            ev[s] = 2'b00;
            rs[s] = 4'd0;
            re[s] = 4'd0;
        end
        for (int e = 0; e < NE; e++) begin
            tgt[e]   = 2'd0;
            isbad[e] = 1'b0;
        end
    endtask

    task automatic run_pass(input bit repulse, input bit scramble);
        int target;
        target = done_seen + 1;
        @(negedge clk);
        go = 1'b1;
        exp_q.push_back(model(cyc));
        @(negedge clk);
        go = 1'b0;
        check("busy_after_go", int'(busy), 1);
        if (scramble) begin
            for (int s = 0; s < N; s++) ev[s] = 2'($urandom);
        end
        if (repulse) begin
            @(negedge clk);
            go = 1'b1;
            @(negedge clk);
            go = 1'b0;
        end
        for (int i = 0; i < 200 && done_seen < target; i++) @(negedge clk);
        if (done_seen < target) begin
            check("pass_timeout", done_seen, target);
            exp_q.delete();
        end
        @(negedge clk);
        check("enable_idle", int'(enable), 1);
        check("busy_idle", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_table();
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_enable", int'(enable), 1);
        check("rst_src_idx", int'(tbl.src_idx), 0);
        check("rst_conn_idx", int'(tbl.conn_idx), 0);
        check("rst_good0", int'(good_tok[0]), 0);
        reset = 1'b0;

        // 1: no events
        run_pass(1'b0, 1'b0);

        // 2: single start, one good and one bad entry
        clear_table();
        ev[1] = 2'b10; rs[1] = 4'd2; re[1] = 4'd4;
        tgt[2] = 2'd0; isbad[2] = 1'b0;
        tgt[3] = 2'd3; isbad[3] = 1'b1;
        run_pass(1'b0, 1'b0);

        // 3: stop event
        clear_table();
        ev[0] = 2'b01; rs[0] = 4'd0; re[0] = 4'd1; tgt[0] = 2'd2;
        run_pass(1'b0, 1'b0);

        // 4: saturation both ways
        clear_table();
        for (int s = 0; s < N; s++) begin
            rs[s] = 4'(3 * s);
            re[s] = 4'(3 * s + 3);
            ev[s] = 2'b10;
        end
        run_pass(1'b0, 1'b0);
        for (int s = 0; s < N; s++) ev[s] = 2'b01;
        run_pass(1'b0, 1'b0);

        // 5: skips; conn_idx stays at the last routed entry (11)
        for (int s = 0; s < N; s++) ev[s] = 2'b00;
        ev[2] = 2'b11;
        ev[3] = 2'b10; rs[3] = 4'd5; re[3] = 4'd5;
        run_pass(1'b0, 1'b0);
        check("skip_conn_idx", int'(tbl.conn_idx), 11);

        // 6: go re-pulsed mid-pass is ignored
        clear_table();
        ev[1] = 2'b10; rs[1] = 4'd2; re[1] = 4'd4;
        tgt[2] = 2'd0; tgt[3] = 2'd3; isbad[3] = 1'b1;
        run_pass(1'b1, 1'b0);

        // 6b: reset in the middle of ROUTE
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("route_conn_idx", int'(tbl.conn_idx), 2);
        check("route_src_idx", int'(tbl.src_idx), 1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_enable", int'(enable), 1);
        check("mid_rst_conn_idx", int'(tbl.conn_idx), 0);
        check("mid_rst_src_idx", int'(tbl.src_idx), 0);
        check("mid_rst_good0", int'(good_tok[0]), 0);
        @(negedge clk);
        reset = 1'b0;
        run_pass(1'b0, 1'b0);

        // 7: randomized passes, tstartstop scrambled after go
        for (int p = 0; p < 25; p++) begin
            for (int s = 0; s < N; s++) begin
                ev[s] = 2'($urandom);
                rs[s] = 4'($urandom_range(0, 15));
                re[s] = 4'($urandom_range(0, 15));
            end
            for (int e = 0; e < NE; e++) begin
                tgt[e]   = 2'($urandom);
                isbad[e] = 1'($urandom);
            end
            run_pass(1'($urandom), 1'b1);
        end

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
